// File: rtl/ddr3_burst_pkg.sv
// Shared types and widths for the DDR3 burst reader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ddr3_burst_pkg;

    localparam int DDR_ADDR_W    = 29;
    localparam int DDR_DATA_W    = 64;
    localparam int DDR_BURST_W   = 8;
    localparam int BURST_MAX_DEF = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPACE,
        ST_REQ,
        ST_RECV
    } rd_state_t;

    // One DDRAM read command as presented on the port.
    typedef struct packed {
        logic [DDR_ADDR_W-1:0]  addr;
        logic [DDR_BURST_W-1:0] cnt;
    } ddr_cmd_t;

    // A zero or oversized burst request falls back to the largest legal burst.
    function automatic logic [DDR_BURST_W-1:0] clamp_burst(
        input logic [DDR_BURST_W-1:0] req,
        input logic [DDR_BURST_W-1:0] bmax
    );
        return ((req == '0) || (req > bmax)) ? bmax : req;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head is visible without a read strobe.
// Latency: a push on cycle B is visible at the head on B+1.
// Backpressure: pushes into a full FIFO are dropped; pops only when head_vld.
module sync_fifo_fwft #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic                     head_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok  = push_vld && (count != CW'(DEPTH));
    assign pop_ok   = pop_rdy && head_vld;
    assign head_vld = (count != '0);
    // Empty FIFO presents zero rather than stale storage.
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    // Storage array: written on push, no reset needed since count gates the head.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr3_burst_reader.sv
// Splits a word-count read into DDRAM bursts and streams the returned beats out.
// Latency: start to first ddram_rd >= 2 cycles; beat to out_valid 1 cycle.
// Backpressure: a burst is issued only when the FIFO can absorb it whole.
module ddr3_burst_reader
    import ddr3_burst_pkg::*;
#(
    parameter int BURST_MAX  = BURST_MAX_DEF,
    parameter int FIFO_DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [DDR_ADDR_W-1:0]  base_addr,
    input  logic [23:0]            total_words,
    input  logic [DDR_BURST_W-1:0] burst_len,
    input  logic                   ddram_busy,
    output logic                   ddram_rd,
    output logic [DDR_ADDR_W-1:0]  ddram_addr,
    output logic [DDR_BURST_W-1:0] ddram_burstcnt,
    input  logic [DDR_DATA_W-1:0]  ddram_dout,
    input  logic                   ddram_dout_ready,
    output logic [DDR_DATA_W-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic                   err_stray
);

    localparam int                     CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DDR_BURST_W-1:0] BMAX    = DDR_BURST_W'(BURST_MAX);
    localparam logic [CW-1:0]          DEPTH_C = CW'(FIFO_DEPTH);

    rd_state_t              state, state_nxt;
    ddr_cmd_t               cmd_q;
    logic [DDR_ADDR_W-1:0]  cur_addr;
    logic [23:0]            remaining;
    logic [DDR_BURST_W-1:0] blen, cur_len, beat_cnt, len;
    logic [CW-1:0]          fifo_count, free_cnt;
    logic                   stop_pend, stop_eff;
    logic                   space_ok, issue, accept, beat, last_beat, start_ok;
    logic                   done_nxt, abort_nxt;

    assign ddram_addr     = cmd_q.addr;
    assign ddram_burstcnt = cmd_q.cnt;
    assign free_cnt       = DEPTH_C - fifo_count;
    assign space_ok       = 32'(free_cnt) >= 32'(len);
    assign stop_eff       = stop_pend | stop;
    assign beat           = ddram_dout_ready && (state == ST_RECV);
    assign last_beat      = beat && (beat_cnt == cur_len - 8'd1);
    assign start_ok       = (state == ST_IDLE) && start && (total_words != '0);

    // Next burst length: the tail burst may be shorter than blen.
    always_comb begin
        len = blen;
        if (remaining < {16'b0, blen}) len = remaining[DDR_BURST_W-1:0];
    end

    // State register plus the registered completion pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            state   <= state_nxt;
            done    <= done_nxt;
            aborted <= abort_nxt;
        end
    end

    // Next-state logic; a pending stop takes priority over issuing a new burst.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        abort_nxt = 1'b0;
        issue     = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (total_words == '0) done_nxt  = 1'b1;
                    else                   state_nxt = ST_SPACE;
                end
            end
            ST_SPACE: begin
                if (stop_eff) begin
                    state_nxt = ST_IDLE;
                    abort_nxt = 1'b1;
                end else if (space_ok) begin
                    issue     = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!ddram_busy) begin
                    accept    = 1'b1;
                    state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                if (last_beat) begin
                    if (remaining == {16'b0, cur_len}) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else if (stop_eff) begin
                        state_nxt = ST_IDLE;
                        abort_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_SPACE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Combinational status outputs.
    always_comb begin
        busy = (state != ST_IDLE);
    end

    // Command register: held stable through wait-request, dropped on acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ddram_rd <= 1'b0;
            cmd_q    <= '0;
            cur_len  <= '0;
        end else if (issue) begin
            ddram_rd  <= 1'b1;
            cmd_q     <= '{addr: cur_addr, cnt: len};
            cur_len   <= len;
        end else if (accept) begin
            ddram_rd  <= 1'b0;
        end
    end

    // Job counters, beat counting, stop latch and stray-beat flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr  <= '0;
            remaining <= '0;
            blen      <= '0;
            beat_cnt  <= '0;
            stop_pend <= 1'b0;
            err_stray <= 1'b0;
        end else begin
            if (start_ok) begin
                cur_addr  <= base_addr;
                remaining <= total_words;
                blen      <= clamp_burst(burst_len, BMAX);
            end
            if (accept)         beat_cnt <= '0;
            else if (beat)      beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) begin
                cur_addr  <= cur_addr + DDR_ADDR_W'(cur_len);
                remaining <= remaining - {16'b0, cur_len};
            end
            if (state_nxt == ST_IDLE)               stop_pend <= 1'b0;
            else if ((state != ST_IDLE) && stop)    stop_pend <= 1'b1;
            if (ddram_dout_ready && (state != ST_RECV)) err_stray <= 1'b1;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DDR_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (beat),
        .push_dat (ddram_dout),
        .pop_rdy  (out_ready),
        .head_vld (out_valid),
        .head_dat (out_data),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_ddr3_burst_reader.sv
// Scoreboard bench for ddr3_burst_reader with a behavioural DDRAM responder.
// Latency: n/a (testbench).
// Backpressure: out_ready and ddram_busy are driven by the directed stimulus.
module tb_ddr3_burst_reader;
    import ddr3_burst_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, start, stop, ddram_busy, out_ready;
    logic [28:0] base_addr;
    logic [23:0] total_words;
    logic [7:0]  burst_len;
    logic        ddram_rd, out_valid, busy, done, aborted, err_stray;
    logic [28:0] ddram_addr;
    logic [7:0]  ddram_burstcnt;
    logic [63:0] ddram_dout, out_data;
    logic        ddram_dout_ready;
    logic        resp_rdy, stray_rdy;

    assign ddram_dout_ready = resp_rdy | stray_rdy;

    always #5 clk = ~clk;

    ddr3_burst_reader #(.BURST_MAX(128), .FIFO_DEPTH(256)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .base_addr(base_addr), .total_words(total_words), .burst_len(burst_len),
        .ddram_busy(ddram_busy), .ddram_rd(ddram_rd), .ddram_addr(ddram_addr),
        .ddram_burstcnt(ddram_burstcnt), .ddram_dout(ddram_dout),
        .ddram_dout_ready(ddram_dout_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
        .aborted(aborted), .err_stray(err_stray)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          abort_cnt = 0;
    logic [63:0] exp_data[$];
    logic [36:0] exp_cmd[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input logic [28:0] a);
        return {3'b000, a, 3'b101, a ^ 29'h15555555};
    endfunction

    task automatic push_cmd(input logic [28:0] a, input logic [7:0] c);
        exp_cmd.push_back({a, c});
    endtask

    task automatic push_words(input logic [28:0] base, input int n);
        for (int i = 0; i < n; i++) exp_data.push_back(word_of(base + 29'(i)));
    endtask

    // DDRAM model: checks each accepted command, then returns its beats back to back.
    initial begin
        int          beats_left;
        logic [28:0] beat_addr;
        beats_left = 0;
        beat_addr  = '0;
        resp_rdy   = 1'b0;
        ddram_dout = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                beats_left = 0;
                resp_rdy   = 1'b0;
            end else begin
                if (beats_left > 0) begin
                    resp_rdy   = 1'b1;
                    ddram_dout = word_of(beat_addr);
                    beat_addr  = beat_addr + 29'd1;
                    beats_left--;
                end else begin
                    resp_rdy   = 1'b0;
                    ddram_dout = 64'hDEAD_BEEF_0BAD_F00D;
                end
                if (ddram_rd && !ddram_busy) begin
                    if (exp_cmd.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_cmd: got addr 0x%0h cnt %0d, expected none",
                                 ddram_addr, ddram_burstcnt);
                    end else begin
                        check("cmd", {27'b0, ddram_addr, ddram_burstcnt}, {27'b0, exp_cmd.pop_front()});
                    end
                    beats_left = int'(ddram_burstcnt);
                    beat_addr  = ddram_addr;
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on every stream handshake, counts pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (done)    done_cnt++;
            if (aborted) abort_cnt++;
            if (reset_n && out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, expected none", out_data);
                end else begin
                    check("data", out_data, exp_data.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [28:0] b, input logic [23:0] n, input logic [7:0] bl);
        start       = 1'b1;
        base_addr   = b;
        total_words = n;
        burst_len   = bl;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        i = 0;
        while ((busy || out_valid) && (i < budget)) begin
            tick();
            i++;
        end
        check({name, "_idle"}, 64'(busy | out_valid), 64'd0);
        tick();
        tick();
        check({name, "_sb_empty"}, 64'(exp_data.size() + exp_cmd.size()), 64'd0);
    endtask

    initial begin
        int d0, a0, k;
        reset_n     = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        ddram_busy  = 1'b0;
        out_ready   = 1'b1;
        stray_rdy   = 1'b0;
        base_addr   = '0;
        total_words = '0;
        burst_len   = '0;
        repeat (3) tick();

        // Reset state
        check("rst_rd",      64'(ddram_rd), 64'd0);
        check("rst_cmd",     {27'b0, ddram_addr, ddram_burstcnt}, 64'd0);
        check("rst_status",  64'({busy, done, aborted, err_stray, out_valid}), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Basic read: two full bursts, plus first-command latency
        d0 = done_cnt;
        push_cmd(29'h2400000, 8'd128);
        push_cmd(29'h2400080, 8'd128);
        push_words(29'h2400000, 256);
        pulse_start(29'h2400000, 24'd256, 8'd128);
        check("basic_busy_n1", 64'(busy), 64'd1);
        check("basic_rd_n1",   64'(ddram_rd), 64'd0);
        tick();
        check("basic_rd_n2",   64'(ddram_rd), 64'd1);
        wait_idle("basic", 1000);
        check("basic_done", 64'(done_cnt - d0), 64'd1);

        // Short tail with burst_len=0 clamped to 128
        d0 = done_cnt;
        push_cmd(29'h0001000, 8'd128);
        push_cmd(29'h0001080, 8'd128);
        push_cmd(29'h0001100, 8'd44);
        push_words(29'h0001000, 300);
        pulse_start(29'h0001000, 24'd300, 8'd0);
        wait_idle("tail", 1500);
        check("tail_done", 64'(done_cnt - d0), 64'd1);

        // Backpressure: only two bursts fit before the FIFO is full
        d0 = done_cnt;
        out_ready = 1'b0;
        push_cmd(29'h0020000, 8'd128);
        push_cmd(29'h0020080, 8'd128);
        push_cmd(29'h0020100, 8'd128);
        push_cmd(29'h0020180, 8'd128);
        push_words(29'h0020000, 512);
        pulse_start(29'h0020000, 24'd512, 8'd128);
        repeat (400) tick();
        check("bp_cmds_left", 64'(exp_cmd.size()), 64'd2);
        check("bp_parked", 64'({busy, ddram_rd, out_valid}), 64'b101);
        out_ready = 1'b1;
        wait_idle("bp", 2000);
        check("bp_done", 64'(done_cnt - d0), 64'd1);

        // Busy stall: command held stable under wait-request
        ddram_busy = 1'b1;
        push_cmd(29'h0003000, 8'd64);
        push_words(29'h0003000, 64);
        pulse_start(29'h0003000, 24'd64, 8'd64);
        k = 0;
        while (!ddram_rd && (k < 10)) begin
            tick();
            k++;
        end
        check("stall_rd_seen", 64'(ddram_rd), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_hold", {27'b0, ddram_rd, ddram_addr, ddram_burstcnt},
                  {27'b0, 1'b1, 29'h0003000, 8'd64});
        end
        ddram_busy = 1'b0;
        tick();
        check("stall_rd_drop", 64'(ddram_rd), 64'd0);
        wait_idle("stall", 500);

        // Stop during the first of four bursts
        d0 = done_cnt;
        a0 = abort_cnt;
        push_cmd(29'h0005000, 8'd128);
        push_words(29'h0005000, 128);
        pulse_start(29'h0005000, 24'd512, 8'd128);
        k = 0;
        while (!out_valid && (k < 50)) begin
            tick();
            k++;
        end
        repeat (20) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle("stop", 500);
        repeat (20) tick();
        check("stop_aborted", 64'(abort_cnt - a0), 64'd1);
        check("stop_no_done", 64'(done_cnt - d0), 64'd0);
        check("stop_rd_low",  64'(ddram_rd), 64'd0);

        // Stray beat while idle
        check("stray_pre", 64'(err_stray), 64'd0);
        stray_rdy = 1'b1;
        tick();
        stray_rdy = 1'b0;
        check("stray_flag", 64'(err_stray), 64'd1);
        check("stray_no_push", 64'(out_valid), 64'd0);
        tick();
        check("stray_sticky", 64'({err_stray, out_valid}), 64'b10);

        // Reset in the middle of a burst, then a normal job
        push_cmd(29'h0007000, 8'd128);
        push_words(29'h0007000, 256);
        pulse_start(29'h0007000, 24'd256, 8'd128);
        k = 0;
        while (!out_valid && (k < 50)) begin
            tick();
            k++;
        end
        repeat (30) tick();
        reset_n = 1'b0;
        #1;
        check("mrst_outputs", {26'b0, ddram_rd, ddram_addr, ddram_burstcnt},
              64'd0);
        check("mrst_status", 64'({busy, out_valid, err_stray}), 64'd0);
        exp_data.delete();
        exp_cmd.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("mrst_fifo_empty", 64'(out_valid), 64'd0);
        d0 = done_cnt;
        push_cmd(29'h0008000, 8'd128);
        push_cmd(29'h0008080, 8'd2);
        push_words(29'h0008000, 130);
        pulse_start(29'h0008000, 24'd130, 8'd128);
        wait_idle("after_rst", 1000);
        check("after_rst_done", 64'(done_cnt - d0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
